// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller client port.
// Models a 2-deep command queue, read latency and refresh stalls.
module sdram_bram_responder #(
    parameter int ADDR_BITS      = 10,
    parameter int RD_LATENCY     = 3,
    parameter int REFRESH_PERIOD = 780,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [21:0] addr,
    input  logic [63:0] wr_data,
    output logic        ack,
    output logic        rd_ack,
    output logic [63:0] rd_data,
    output logic        busy,
    output logic        overflow
);

    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    typedef struct packed {
        logic                 wr;
        logic [ADDR_BITS-1:0] addr;
        logic [63:0]          data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        REFRESH
    } state_t;

    state_t      state, state_n;
    cmd_t        q0, q1, q_new;
    logic [1:0]  cnt;
    logic        pop, push, take_ref;
    logic [3:0]  lat_cnt;
    logic [7:0]  ref_cyc;
    logic [RW-1:0] ref_cnt;
    logic        ref_pend, wrap;
    logic [63:0] rd_word;
    logic        rd_done;
    logic        unused_addr;

    logic [63:0] mem [0:(2**ADDR_BITS)-1];

    // High address bits alias onto the implemented depth.
    assign unused_addr = ^addr[21:ADDR_BITS];
    assign q_new       = '{wr: wr, addr: addr[ADDR_BITS-1:0], data: wr_data};
    assign push        = req && ((cnt != 2'd2) || pop);
    assign wrap        = (REFRESH_PERIOD != 0) &&
                         (ref_cnt == RW'(REFRESH_PERIOD - 1));
    assign rd_done     = (state == READ_WAIT) && (lat_cnt == 4'd1);
    assign busy        = (cnt != 2'd0) || (state != IDLE);

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        take_ref = 1'b0;
        unique case (state)
            IDLE: begin
                if (ref_pend) begin
                    state_n  = REFRESH;
                    take_ref = 1'b1;
                end else if (cnt != 2'd0) begin
                    pop = 1'b1;
                    if (!q0.wr)
                        state_n = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (lat_cnt == 4'd1)
                    state_n = IDLE;
            end
            REFRESH: begin
                if (ref_cyc == 8'd1)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            q0       <= '0;
            q1       <= '0;
            ack      <= 1'b0;
            rd_ack   <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
            lat_cnt  <= 4'd0;
            ref_cyc  <= 8'd0;
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            state    <= state_n;
            ack      <= pop;
            rd_ack   <= rd_done;
            overflow <= overflow | (req & ~push);
            ref_pend <= (ref_pend & ~take_ref) | wrap;

            if (rd_done)
                rd_data <= rd_word;

            if (REFRESH_PERIOD != 0)
                ref_cnt <= wrap ? '0 : ref_cnt + RW'(1);

            if (pop && !q0.wr)
                lat_cnt <= 4'(RD_LATENCY);
            else if (state == READ_WAIT)
                lat_cnt <= lat_cnt - 4'd1;

            if (take_ref)
                ref_cyc <= 8'(REFRESH_CYCLES);
            else if (state == REFRESH)
                ref_cyc <= ref_cyc - 8'd1;

            // Head stays in q0; a full queue accepts only when it also drains.
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0)
                        q0 <= q_new;
                    else
                        q1 <= q_new;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    q0  <= q1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        q0 <= q_new;
                    end else begin
                        q0 <= q1;
                        q1 <= q_new;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory survives reset; a popped write is never undone.
    always_ff @(posedge clk) begin
        if (pop && q0.wr)
            mem[q0.addr] <= q0.data;
        if (pop && !q0.wr)
            rd_word <= mem[q0.addr];
    end

endmodule
